// File: rtl/wavegen_pkg.sv
// Shared constants for the waveform generator: legal frequency limits, sweep mode codes
// and the sweep FSM state encoding.
package wavegen_pkg;

    localparam int unsigned FREQ_MIN_HZ = 1000;
    localparam int unsigned FREQ_MAX_HZ = 999999;
    localparam int unsigned FREQ_W      = 20;

    localparam logic [FREQ_W-1:0] FREQ_RESET = 20'd100000;

    localparam logic [1:0] SWEEP_OFF = 2'b00;
    localparam logic [1:0] SAW_UP    = 2'b01;
    localparam logic [1:0] SAW_DN    = 2'b10;
    localparam logic [1:0] TRI       = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN_UP = 2'd1;
    localparam logic [1:0] ST_RUN_DN = 2'd2;

endpackage

// File: rtl/sweep_engine_ms_tick_gen.sv
// Free-running mod-DIV counter producing a one-cycle tick at terminal count; a sync
// clear restarts the period so the first step after a mode change is a full period away.
module ms_tick_gen
    import wavegen_pkg::*;
#(
    parameter int unsigned DIV = 100_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned     CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == TERM)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == TERM);

endmodule

// File: rtl/sweep_engine.sv
// Sweep engine: steps the output frequency once per millisecond between bounds derived
// from the centre frequency and half-span, in sawtooth or triangle fashion.
module sweep_engine
    import wavegen_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned FREQ_MIN = FREQ_MIN_HZ,
    parameter int unsigned FREQ_MAX = FREQ_MAX_HZ
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [19:0] base_freq,
    input  logic [16:0] sweep_range,
    input  logic [12:0] sweep_speed,
    input  logic [1:0]  sweep_mode,
    output logic [19:0] sweep_freq,
    output logic        sweep_active,
    output logic        sweep_dir,
    output logic        wrap_pulse
);

    localparam int unsigned             TICK_DIV   = CLK_HZ / 1000;
    localparam logic signed [21:0]      FREQ_MIN_S = 22'(FREQ_MIN);
    localparam logic signed [21:0]      FREQ_MAX_S = 22'(FREQ_MAX);

    function automatic logic signed [21:0] min_s(input logic signed [21:0] a,
                                                 input logic signed [21:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic signed [21:0] max_s(input logic signed [21:0] a,
                                                 input logic signed [21:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [19:0] to_freq(input logic signed [21:0] x);
        return x[19:0];
    endfunction

    logic [19:0] freq_q, freq_d;
    logic [1:0]  state_q, state_d;
    logic [1:0]  mode_q;
    logic        wrap_q, wrap_d;
    logic        active_q, active_d;
    logic        mode_chg;
    logic        tick;

    logic signed [21:0] base_s, range_s, speed_s, cur_s;
    logic signed [21:0] lo_s, hi_s, up_s, dn_s;

    assign mode_chg = (sweep_mode != mode_q);

    ms_tick_gen #(
        .DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (mode_chg),
        .tick (tick)
    );

    // Signed 22-bit math so base-range underflow is visible before clamping.
    always_comb begin
        base_s  = $signed({2'b00, base_freq});
        range_s = $signed({5'b00000, sweep_range});
        speed_s = $signed({9'b000000000, sweep_speed});
        cur_s   = $signed({2'b00, freq_q});
        lo_s    = max_s(base_s - range_s, FREQ_MIN_S);
        hi_s    = min_s(base_s + range_s, FREQ_MAX_S);
        up_s    = cur_s + speed_s;
        dn_s    = cur_s - speed_s;
    end

    always_comb begin
        freq_d   = freq_q;
        state_d  = state_q;
        wrap_d   = 1'b0;
        active_d = (sweep_mode != SWEEP_OFF);

        if (mode_chg || (sweep_mode == SWEEP_OFF)) begin
            case (sweep_mode)
                SWEEP_OFF: begin
                    freq_d  = base_freq;
                    state_d = ST_IDLE;
                end
                SAW_DN: begin
                    freq_d  = to_freq(hi_s);
                    state_d = ST_RUN_DN;
                end
                default: begin
                    freq_d  = to_freq(lo_s);
                    state_d = ST_RUN_UP;
                end
            endcase
        end else if (tick) begin
            case (sweep_mode)
                SAW_UP: begin
                    if (cur_s >= hi_s) begin
                        freq_d = to_freq(lo_s);
                        wrap_d = 1'b1;
                    end else begin
                        freq_d = to_freq(min_s(up_s, hi_s));
                    end
                end
                SAW_DN: begin
                    if (cur_s <= lo_s) begin
                        freq_d = to_freq(hi_s);
                        wrap_d = 1'b1;
                    end else begin
                        freq_d = to_freq(max_s(dn_s, lo_s));
                    end
                end
                default: begin
                    if (state_q == ST_RUN_DN) begin
                        if (cur_s <= lo_s + speed_s) begin
                            freq_d  = to_freq(lo_s);
                            state_d = ST_RUN_UP;
                            wrap_d  = 1'b1;
                        end else begin
                            freq_d = to_freq(dn_s);
                        end
                    end else begin
                        if (up_s >= hi_s) begin
                            freq_d  = to_freq(hi_s);
                            state_d = ST_RUN_DN;
                            wrap_d  = 1'b1;
                        end else begin
                            freq_d = to_freq(up_s);
                        end
                    end
                end
            endcase
        end else begin
            // Between ticks, pull the output back inside live-edited bounds.
            freq_d = to_freq(min_s(max_s(cur_s, lo_s), hi_s));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            freq_q   <= FREQ_RESET;
            state_q  <= ST_IDLE;
            mode_q   <= SWEEP_OFF;
            wrap_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            freq_q   <= freq_d;
            state_q  <= state_d;
            mode_q   <= sweep_mode;
            wrap_q   <= wrap_d;
            active_q <= active_d;
        end
    end

    assign sweep_freq   = freq_q;
    assign sweep_active = active_q;
    assign sweep_dir    = (state_q == ST_RUN_DN);
    assign wrap_pulse   = wrap_q;

endmodule

// File: tb/tb_sweep_engine.sv
// Bench for sweep_engine: directed scenarios with literal expectations, then randomized
// mode/parameter traffic compared every cycle against a behavioural model.
module tb_sweep_engine;

    localparam int CLK_HZ = 10_000;
    localparam int DIV    = CLK_HZ / 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [19:0] base_freq;
    logic [16:0] sweep_range;
    logic [12:0] sweep_speed;
    logic [1:0]  sweep_mode;
    logic [19:0] sweep_freq;
    logic        sweep_active;
    logic        sweep_dir;
    logic        wrap_pulse;

    int tests = 0;
    int fails = 0;

    // Model state: what the outputs must be after the most recent clock edge.
    int m_freq = 100000;
    int m_act  = 0;
    int m_dir  = 0;
    int m_wrap = 0;
    int m_cnt  = 0;
    int m_prev = 0;

    sweep_engine #(
        .CLK_HZ(CLK_HZ)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .base_freq   (base_freq),
        .sweep_range (sweep_range),
        .sweep_speed (sweep_speed),
        .sweep_mode  (sweep_mode),
        .sweep_freq  (sweep_freq),
        .sweep_active(sweep_active),
        .sweep_dir   (sweep_dir),
        .wrap_pulse  (wrap_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int b, input int r, input int s, input int md);
        base_freq   = 20'(b);
        sweep_range = 17'(r);
        sweep_speed = 13'(s);
        sweep_mode  = 2'(md);
    endtask

    // Behavioural model: frequency evolves by the sweep rules, one step per ms tick.
    always @(posedge clk) begin
        int b, r, s, md, lo, hi;
        bit tk, chg;
        b  = int'(base_freq);
        r  = int'(sweep_range);
        s  = int'(sweep_speed);
        md = int'(sweep_mode);
        if (!rst_n) begin
            m_freq = 100000; m_act = 0; m_dir = 0; m_wrap = 0; m_cnt = 0; m_prev = 0;
        end else begin
            lo = (b - r < 1000) ? 1000 : b - r;
            hi = (b + r > 999999) ? 999999 : b + r;
            tk  = (m_cnt == DIV - 1);
            chg = (md != m_prev);
            m_wrap = 0;
            if (md == 0) begin
                m_freq = b;
                m_dir  = 0;
            end else if (chg) begin
                m_dir  = (md == 2) ? 1 : 0;
                m_freq = (md == 2) ? hi : lo;
            end else if (tk) begin
                if (md == 1) begin
                    if (m_freq >= hi) begin m_freq = lo; m_wrap = 1; end
                    else m_freq = (m_freq + s > hi) ? hi : m_freq + s;
                end else if (md == 2) begin
                    if (m_freq <= lo) begin m_freq = hi; m_wrap = 1; end
                    else m_freq = (m_freq - s < lo) ? lo : m_freq - s;
                end else if (m_dir == 0) begin
                    if (m_freq + s >= hi) begin m_freq = hi; m_dir = 1; m_wrap = 1; end
                    else m_freq = m_freq + s;
                end else begin
                    if (m_freq <= lo + s) begin m_freq = lo; m_dir = 0; m_wrap = 1; end
                    else m_freq = m_freq - s;
                end
            end else begin
                if (m_freq < lo) m_freq = lo;
                if (m_freq > hi) m_freq = hi;
            end
            m_cnt  = (chg || tk) ? 0 : m_cnt + 1;
            m_act  = (md != 0) ? 1 : 0;
            m_prev = md;
        end
    end

    always @(negedge clk) begin
        check("model_freq",   int'(sweep_freq),   m_freq);
        check("model_active", int'(sweep_active), m_act);
        check("model_dir",    int'(sweep_dir),    m_dir);
        check("model_wrap",   int'(wrap_pulse),   m_wrap);
    end

    initial begin
        int tri_f[8] = '{98000, 101000, 104000, 105000, 102000, 99000, 96000, 95000};
        int tri_d[8] = '{0, 0, 0, 1, 1, 1, 1, 0};
        int tri_w[8] = '{0, 0, 0, 1, 0, 0, 0, 1};

        rst_n = 1'b0;
        set_in(123456, 0, 0, 0);
        cyc(2);
        check("reset_freq",   int'(sweep_freq),   100000);
        check("reset_active", int'(sweep_active), 0);
        check("reset_dir",    int'(sweep_dir),    0);
        check("reset_wrap",   int'(wrap_pulse),   0);
        rst_n = 1'b1;
        cyc(1);

        set_in(250000, 0, 0, 0);
        cyc(1);
        check("idle_freq",   int'(sweep_freq),   250000);
        check("idle_active", int'(sweep_active), 0);

        set_in(100000, 20000, 1000, 1);
        cyc(1);
        check("saw_up_start",  int'(sweep_freq),   80000);
        check("saw_up_active", int'(sweep_active), 1);
        cyc(400);
        check("saw_up_tick40", int'(sweep_freq), 120000);
        check("saw_up_nowrap", int'(wrap_pulse), 0);
        cyc(10);
        check("saw_up_wrap_freq", int'(sweep_freq), 80000);
        check("saw_up_wrap",      int'(wrap_pulse), 1);

        set_in(100000, 5000, 3000, 3);
        cyc(1);
        check("tri_start", int'(sweep_freq), 95000);
        for (int i = 0; i < 8; i++) begin
            cyc(10);
            check("tri_freq", int'(sweep_freq), tri_f[i]);
            check("tri_dir",  int'(sweep_dir),  tri_d[i]);
            check("tri_wrap", int'(wrap_pulse), tri_w[i]);
        end

        set_in(2000, 20000, 3000, 2);
        cyc(1);
        check("saw_dn_start", int'(sweep_freq), 22000);
        check("saw_dn_dir",   int'(sweep_dir),  1);
        cyc(70);
        check("lo_clamp", int'(sweep_freq), 1000);
        cyc(10);
        check("saw_dn_wrap_freq", int'(sweep_freq), 22000);
        check("saw_dn_wrap",      int'(wrap_pulse), 1);
        set_in(990000, 20000, 3000, 0);
        cyc(1);
        set_in(990000, 20000, 3000, 2);
        cyc(1);
        check("hi_clamp", int'(sweep_freq), 999999);

        set_in(300000, 10000, 0, 1);
        cyc(1);
        check("speed0_start", int'(sweep_freq), 290000);
        cyc(200);
        check("speed0_hold", int'(sweep_freq), 290000);

        set_in(400000, 0, 500, 3);
        cyc(1);
        check("range0_start", int'(sweep_freq), 400000);
        cyc(10);
        check("range0_freq", int'(sweep_freq), 400000);
        check("range0_wrap", int'(wrap_pulse), 1);
        cyc(10);
        check("range0_wrap2", int'(wrap_pulse), 1);

        set_in(100000, 20000, 1000, 1);
        cyc(1);
        cyc(25);
        check("mid_pre", int'(sweep_freq), 82000);
        set_in(100000, 20000, 1000, 2);
        cyc(1);
        check("mid_switch_hi",  int'(sweep_freq), 120000);
        check("mid_switch_dir", int'(sweep_dir),  1);
        cyc(9);
        check("mid_no_early_tick", int'(sweep_freq), 120000);
        cyc(1);
        check("mid_first_step", int'(sweep_freq), 119000);

        cyc(13);
        rst_n = 1'b0;
        cyc(1);
        check("midrst_freq",   int'(sweep_freq),   100000);
        check("midrst_active", int'(sweep_active), 0);
        check("midrst_dir",    int'(sweep_dir),    0);
        check("midrst_wrap",   int'(wrap_pulse),   0);
        rst_n = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 149) == 0) sweep_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) base_freq = 20'($urandom_range(1000, 999999));
            if ($urandom_range(0, 299) == 0) sweep_range = 17'($urandom_range(0, 1) != 0 ?
                                               $urandom_range(0, 50000) : $urandom_range(0, 3000));
            if ($urandom_range(0, 199) == 0) sweep_speed = 13'($urandom_range(0, 4000));
            rst_n = ($urandom_range(0, 1499) == 0) ? 1'b0 : 1'b1;
            cyc(1);
        end
        rst_n = 1'b1;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
